// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and sizing helpers for serial_adder.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int num_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter is never narrower than one bit, even for a single-step adder.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: two half adders whose carries are ORed.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g, t;

  assign p  = a ^ b;
  assign g  = a & b;
  assign s  = p ^ ci;
  assign t  = p & ci;
  assign co = g | t;
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB digit first, registered carry.
// Define SERIAL_ADDER_SUB_EN to add the SUB port (A - B, C=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             C
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             SUB
`endif
);
  localparam int N  = num_steps(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $fatal(1, "serial_adder: DIGIT must be >=1 and divide WIDTH");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic [WIDTH-1:0] dsum_top;
  logic             sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub = SUB;
`else
  assign sub = 1'b0;
`endif

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic ci, co;
    if (i == 0) begin : g_first
      assign ci = carry;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    fa_cell u_fa (.a(a_reg[i]), .b(b_reg[i]), .ci(ci), .s(dsum[i]), .co(co));
  end
  assign dcarry = g_fa[DIGIT-1].co;

  // New digit enters S from the top so the LSB digit lands at bit 0 after N steps.
  assign dsum_top = WIDTH'(dsum) << (WIDTH - DIGIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (IN_VALID) begin
          // Subtract is A + ~B + 1: invert B and force the carry-in.
          a_reg <= A;
          b_reg <= sub ? ~B : B;
          carry <= sub ? 1'b1 : CIN;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          s_reg <= (s_reg >> DIGIT) | dsum_top;
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= dcarry;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (OUT_READY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign S         = s_reg;
  assign C         = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (8/1, 8/4, 1/1).
module tb_serial_adder;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic       iv0, iv1, iv2, ordy0, ordy1, ordy2, cin0, cin1, cin2;
  logic [7:0] a0, b0, a1, b1;
  logic       a2, b2;
  logic       ir0, ir1, ir2, ov0, ov1, ov2, c0, c1, c2;
  logic [7:0] s0, s1;
  logic       s2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub0;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv0), .IN_READY(ir0), .A(a0), .B(b0),
    .CIN(cin0), .OUT_VALID(ov0), .OUT_READY(ordy0), .S(s0), .C(c0)
`ifdef SERIAL_ADDER_SUB_EN
    , .SUB(sub0)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
    .CIN(cin1), .OUT_VALID(ov1), .OUT_READY(ordy1), .S(s1), .C(c1)
`ifdef SERIAL_ADDER_SUB_EN
    , .SUB(1'b0)
`endif
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv2), .IN_READY(ir2), .A(a2), .B(b2),
    .CIN(cin2), .OUT_VALID(ov2), .OUT_READY(ordy2), .S(s2), .C(c2)
`ifdef SERIAL_ADDER_SUB_EN
    , .SUB(1'b0)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [8:0] expq[3][$];
  int         accq[3][$];
  bit         prev_ov[3];
  bit         hs_prev[3];
  int         nsteps[3] = '{8, 2, 1};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic get_ir(input int id);
    case (id)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  task automatic set_in(input int id, input logic v, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb);
    case (id)
      0: begin
        iv0 = v; a0 = av; b0 = bv; cin0 = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub0 = sb;
`endif
      end
      1: begin iv1 = v; a1 = av; b1 = bv; cin1 = ci; end
      default: begin iv2 = v; a2 = av[0]; b2 = bv[0]; cin2 = ci; end
    endcase
    if (sb && id != 0) $display("note: SUB only wired on instance 0");
  endtask

  // Issue one operation; push the hand-computed result unless it will be aborted.
  task automatic issue(input int id, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic sb, input bit push, input logic [7:0] es, input logic ec);
    bit ok, done;
    done = 0;
    if (push) expq[id].push_back({ec, es});
    @(posedge CLK); #1 set_in(id, 1'b1, av, bv, ci, sb);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge CLK); ok = get_ir(id);
      @(posedge CLK); if (ok) done = 1;
    end
    #1 set_in(id, 1'b0, av, bv, ci, 1'b0);
    if (!done) chk($sformatf("d%0d_accept_timeout", id), 0, 1);
  endtask

  task automatic mon(input int id, input logic iv_, input logic ir_, input logic ov_,
                     input logic or_, input logic [7:0] s_, input logic c_);
    logic [8:0] e;
    if (hs_prev[id]) begin
      chk($sformatf("d%0d_valid_after_hs", id), ov_, 0);
      chk($sformatf("d%0d_ready_after_hs", id), ir_, 1);
    end
    if (ov_) begin
      chk($sformatf("d%0d_ready_in_done", id), ir_, 0);
      if (!prev_ov[id]) begin
        if (accq[id].size() == 0) chk($sformatf("d%0d_latency_noacc", id), 1, 0);
        else chk($sformatf("d%0d_latency", id), cyc - accq[id].pop_front(), nsteps[id]);
      end
      if (expq[id].size() == 0) chk($sformatf("d%0d_unexpected_result", id), {c_, s_}, 9'h1FF);
      else begin
        e = expq[id][0];
        chk($sformatf("d%0d_sum", id), s_, e[7:0]);
        chk($sformatf("d%0d_carry", id), c_, e[8]);
        if (or_) void'(expq[id].pop_front());
      end
    end
    if (iv_ && ir_) accq[id].push_back(cyc + 1);
    prev_ov[id] = ov_;
    hs_prev[id] = ov_ && or_;
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      mon(0, iv0, ir0, ov0, ordy0, s0, c0);
      mon(1, iv1, ir1, ov1, ordy1, s1, c1);
      mon(2, iv2, ir2, ov2, ordy2, {7'b0, s2}, c2);
    end
  end

  task automatic clear_sb();
    for (int i = 0; i < 3; i++) begin
      expq[i].delete(); accq[i].delete(); prev_ov[i] = 0; hs_prev[i] = 0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (expq[0].size() + expq[1].size() + expq[2].size()) != 0; k++)
      @(negedge CLK);
    chk("drain_pending", expq[0].size() + expq[1].size() + expq[2].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    ordy0 = 1; ordy1 = 1; ordy2 = 1;
    clear_sb();
    repeat (2) @(negedge CLK);
    chk("rst_ov0", ov0, 0); chk("rst_s0", s0, 0); chk("rst_c0", c0, 0);
    chk("rst_ov1", ov1, 0); chk("rst_s1", s1, 0); chk("rst_c1", c1, 0);
    chk("rst_ov2", ov2, 0); chk("rst_s2", s2, 0); chk("rst_c2", c2, 0);
    RST_N = 1;
    @(posedge CLK); #1;
    chk("rst_ir0", ir0, 1); chk("rst_ir1", ir1, 1); chk("rst_ir2", ir2, 1);

    // WIDTH=1 truth table
    issue(2, 8'h0, 8'h0, 1'b0, 1'b0, 1, 8'h0, 1'b0);
    issue(2, 8'h0, 8'h1, 1'b0, 1'b0, 1, 8'h1, 1'b0);
    issue(2, 8'h1, 8'h0, 1'b0, 1'b0, 1, 8'h1, 1'b0);
    issue(2, 8'h1, 8'h1, 1'b0, 1'b0, 1, 8'h0, 1'b1);
    // WIDTH=8, DIGIT=1
    issue(0, 8'h0F, 8'h01, 1'b0, 1'b0, 1, 8'h10, 1'b0);
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1, 8'h00, 1'b1);
    // WIDTH=8, DIGIT=4
    issue(1, 8'hAB, 8'h55, 1'b1, 1'b0, 1, 8'h01, 1'b1);
    issue(1, 8'h80, 8'h80, 1'b0, 1'b0, 1, 8'h00, 1'b1);
    issue(1, 8'h12, 8'h34, 1'b1, 1'b0, 1, 8'h47, 1'b0);
    drain();

    // Backpressure: result held, new requests ignored while DONE
    ordy0 = 0;
    issue(0, 8'h3C, 8'h42, 1'b0, 1'b0, 1, 8'h7E, 1'b0);
    for (int k = 0; k < 50 && !ov0; k++) @(negedge CLK);
    chk("bp_reached_done", ov0, 1);
    set_in(0, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      chk("bp_ready_low", ir0, 0);
    end
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge CLK); #1 ordy0 = 1;
    drain();

    // Reset mid-RUN discards the partial result
    issue(0, 8'h5A, 8'hA5, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    repeat (3) @(posedge CLK);
    #2 RST_N = 0;
    #1;
    chk("midrun_rst_ov0", ov0, 0); chk("midrun_rst_s0", s0, 0); chk("midrun_rst_c0", c0, 0);
    clear_sb();
    repeat (2) @(posedge CLK);
    #2 RST_N = 1;
    @(posedge CLK); #1;
    chk("midrun_rst_ir0", ir0, 1);
    issue(0, 8'h12, 8'h34, 1'b1, 1'b0, 1, 8'h47, 1'b0);
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    issue(0, 8'h05, 8'h07, 1'b1, 1'b1, 1, 8'hFE, 1'b0);
    issue(0, 8'h07, 8'h05, 1'b1, 1'b1, 1, 8'h02, 1'b1);
    drain();
`endif

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built from a chain of DIGIT full-adder cells. Each cell is two half adders plus an OR. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It adds DIGIT bits per clock, least significant digit first, with a registered carry between digits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It replaces single-bit half/full adders wherever area matters more than latency, and is the datapath primitive for the team's narrow accumulators.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; must be ≥1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous assertion, active-low.
- IN_VALID  in  1  operands A, B, CIN present.
- IN_READY  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in.
- OUT_VALID  out  1  result S, C valid.
- OUT_READY  in  1  consumer accepts result.
- S  out  WIDTH  sum.
- C  out  1  carry-out.
- SUB  in  1  subtract mode; port exists only when SERIAL_ADDER_SUB_EN is defined.

## Operation
- N = WIDTH/DIGIT digit steps. Digit counter width is clog2(N), minimum 1.
- FSM states:
  - IDLE: IN_READY=1. IN_VALID&&IN_READY captures A, B and CIN into internal shift registers, clears the counter, and goes to RUN.
  - RUN: each cycle adds the low DIGIT bits of the A and B registers plus the carry register. The DIGIT sum bits shift into S from the top, both operand registers shift right by DIGIT, the carry register takes the cell carry-out, and the counter increments. After step N−1 the FSM goes to DONE.
  - DONE: OUT_VALID=1. S and C are held stable until OUT_READY, then the FSM goes to IDLE.
- No overlap: IN_READY=0 in RUN and DONE. Inputs are ignored outside IDLE.
- Arithmetic: {C,S} = A + B + CIN, exact modulo 2^(WIDTH+1). No saturation.
- IN_VALID may drop without completion while in IDLE; nothing is captured.
- Reset values:
  - State IDLE, IN_READY=1 while RST_N is high.
  - OUT_VALID=0, S=0, C=0.
  - Counter, carry and operand registers are all 0.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial result is discarded and never presented.

## Timing
- Acceptance at edge t0. RUN occupies edges t0+1…t0+N. OUT_VALID rises after edge t0+N, so latency is N cycles.
- Result handshake at edge t1 (OUT_VALID&&OUT_READY): OUT_VALID=0 and IN_READY=1 after t1. The next acceptance is possible at edge t1+1.
- Throughput, zero backpressure: one result per N+2 cycles.
- If OUT_READY is already high when DONE is entered, the result is held for exactly one cycle.
- The combinational path is the DIGIT-cell ripple only. No input-to-output combinational path.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds the SUB port, sampled with the operands.
  - SUB=1 computes A + ~B + 1, i.e. A−B, and ignores CIN. C=1 means no borrow.
- Undefined: no SUB port, add only. Logic is identical to SUB tied 0.

## Structure
- serial_adder_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - a function computing N and the counter width from WIDTH/DIGIT.
- Sub-module fa_cell: 1-bit full adder (two half adders, carry OR), instantiated DIGIT times in a generate loop. It is the natural reuse point for the existing half-adder cell.

## Test plan
- WIDTH=1, DIGIT=1, CIN=0, A/B = 00, 01, 10, 11 -> S/C = 0/0, 1/0, 1/0, 0/1. OUT_VALID 1 cycle after each acceptance.
- WIDTH=8, DIGIT=1: A=0x0F, B=0x01, CIN=0 -> S=0x10, C=0, OUT_VALID exactly 8 cycles after acceptance. Then A=0xFF, B=0x01, CIN=0 -> S=0x00, C=1.
- WIDTH=8, DIGIT=4: A=0xAB, B=0x55, CIN=1 -> S=0x01, C=1, latency 2 cycles.
- Backpressure: OUT_READY held low 5 cycles after OUT_VALID -> S and C stable, IN_READY=0, new IN_VALID ignored. One cycle after OUT_READY rises, IN_READY=1.
- Reset: RST_N pulsed low 3 cycles into RUN -> OUT_VALID=0, S=0, C=0 immediately; IN_READY=1 after release; the following operation is correct.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: A=0x05, B=0x07, SUB=1 -> S=0xFE, C=0. A=0x07, B=0x05, SUB=1 -> S=0x02, C=1.
